multicycle_sequencer: RTL and testbench

- FSM that sequences the RV32 subset datapath (R-type ADD/SUB/AND/XOR/SLL, ADDI/LI, LW, SW, LUI) as a multi-cycle machine over one shared instruction/data memory port with a req/ack handshake.
- Sits between the combinational control unit and the datapath registers and memory.
- Generates the PC, instruction-register, register-file and memory enables.
- Gates the control unit's RegWrite/MemWrite so they take effect only in the correct cycle.

---
 rtl/multicycle_sequencer_if.sv | 22 ++
 rtl/multicycle_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_multicycle_sequencer.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_sequencer_if.sv
// Shared instruction/data memory port between the sequencer and the memory.
// The sequencer owns the request side; memory answers with a single-cycle ack.
interface multicycle_sequencer_if;
  logic mem_req;
  logic mem_ack;
  logic mem_addr_sel;
  logic mem_we;

  modport master (
    output mem_req,
    output mem_addr_sel,
    output mem_we,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_addr_sel,
    input  mem_we,
    output mem_ack
  );
endinterface

// File: rtl/multicycle_sequencer.sv
// Multi-cycle sequencer for the RV32 subset datapath (R-type, ADDI/LI, LW, SW, LUI).
// Walks each instruction through FETCH/DECODE/EXEC/MEM/WB over a single shared
// memory port, and gates the control unit's write enables to the right cycle.
// Any memory request left unacknowledged for MEM_TIMEOUT cycles, or an
// unsupported opcode, parks the machine in ERROR until reset.
module multicycle_sequencer #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_start,
  input  logic                         i_stop,
  input  logic [6:0]                   i_opcode,
  input  logic                         i_ctl_reg_write,
  input  logic                         i_ctl_mem_write,
  multicycle_sequencer_if.master       mem,
  output logic                         o_ir_write,
  output logic                         o_pc_write,
  output logic                         o_reg_write_en,
  output logic                         o_busy,
  output logic                         o_err,
  output logic [1:0]                   o_err_code,
  output logic [CNT_W-1:0]             o_retired
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_ERROR
  } state_t;

  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  // The wait counter holds the number of unacked request cycles already seen,
  // so the last allowed cycle is the one where it equals MEM_TIMEOUT-1.
  localparam logic [7:0] WAIT_LIMIT = 8'(MEM_TIMEOUT - 1);

  state_t           r_state;
  state_t           w_nextState;
  logic [7:0]       r_waitCnt;
  logic [7:0]       w_waitCntNext;
  logic             r_err;
  logic [1:0]       r_errCode;
  logic [CNT_W-1:0] r_retired;

  logic             w_isLoad;
  logic             w_isStore;
  logic             w_isLegal;
  logic             w_timeoutHit;
  logic             w_memReq;
  logic             w_memAddrSel;
  logic             w_memWe;
  logic             w_irWrite;
  logic             w_pcWrite;
  logic             w_regWriteEn;
  logic             w_retire;
  logic [1:0]       w_setCode;

  assign w_isLoad     = (i_opcode == OP_LOAD);
  assign w_isStore    = (i_opcode == OP_STORE);
  assign w_isLegal    = (i_opcode == OP_RTYPE) || (i_opcode == OP_ITYPE) ||
                        (i_opcode == OP_LUI)   || w_isLoad || w_isStore;
  assign w_timeoutHit = (r_waitCnt == WAIT_LIMIT);

  // State register, wait counter, sticky error and retired-instruction counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_waitCnt <= 8'd0;
      r_err     <= 1'b0;
      r_errCode <= ERR_NONE;
      r_retired <= '0;
    end else begin
      r_state   <= w_nextState;
      r_waitCnt <= w_waitCntNext;
      if (w_setCode != ERR_NONE) begin
        r_err     <= 1'b1;
        r_errCode <= w_setCode;
      end
      if (w_retire) begin
        r_retired <= r_retired + CNT_W'(1);
      end
    end
  end

  // Next-state and strobe decode; ack only matters in FETCH and MEM, and the
  // wait counter is cleared on every entry into a requesting state.
  always_comb begin
    w_nextState   = r_state;
    w_waitCntNext = r_waitCnt;
    w_memReq      = 1'b0;
    w_memAddrSel  = 1'b0;
    w_memWe       = 1'b0;
    w_irWrite     = 1'b0;
    w_pcWrite     = 1'b0;
    w_regWriteEn  = 1'b0;
    w_retire      = 1'b0;
    w_setCode     = ERR_NONE;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_nextState   = S_FETCH;
          w_waitCntNext = 8'd0;
        end
      end
      S_FETCH: begin
        w_memReq = 1'b1;
        if (mem.mem_ack) begin
          w_irWrite   = 1'b1;
          w_nextState = S_DECODE;
        end else if (w_timeoutHit) begin
          w_nextState = S_ERROR;
          w_setCode   = ERR_TIMEOUT;
        end else begin
          w_waitCntNext = r_waitCnt + 8'd1;
        end
      end
      S_DECODE: begin
        if (w_isLegal) begin
          w_nextState = S_EXEC;
        end else begin
          w_nextState = S_ERROR;
          w_setCode   = ERR_ILLEGAL;
        end
      end
      S_EXEC: begin
        if (w_isLoad || w_isStore) begin
          w_nextState   = S_MEM;
          w_waitCntNext = 8'd0;
        end else begin
          w_nextState = S_WB;
        end
      end
      S_MEM: begin
        w_memReq     = 1'b1;
        w_memAddrSel = 1'b1;
        w_memWe      = i_ctl_mem_write && w_isStore;
        if (mem.mem_ack) begin
          if (w_isStore) begin
            w_pcWrite     = 1'b1;
            w_retire      = 1'b1;
            w_nextState   = i_stop ? S_IDLE : S_FETCH;
            w_waitCntNext = 8'd0;
          end else begin
            w_nextState = S_WB;
          end
        end else if (w_timeoutHit) begin
          w_nextState = S_ERROR;
          w_setCode   = ERR_TIMEOUT;
        end else begin
          w_waitCntNext = r_waitCnt + 8'd1;
        end
      end
      S_WB: begin
        w_regWriteEn  = i_ctl_reg_write;
        w_pcWrite     = 1'b1;
        w_retire      = 1'b1;
        w_nextState   = i_stop ? S_IDLE : S_FETCH;
        w_waitCntNext = 8'd0;
      end
      S_ERROR: begin
        w_nextState = S_ERROR;
      end
      default: begin
        w_nextState = S_IDLE;
      end
    endcase
  end

  assign mem.mem_req      = w_memReq;
  assign mem.mem_addr_sel = w_memAddrSel;
  assign mem.mem_we       = w_memWe;
  assign o_ir_write       = w_irWrite;
  assign o_pc_write       = w_pcWrite;
  assign o_reg_write_en   = w_regWriteEn;
  assign o_busy           = (r_state != S_IDLE) && (r_state != S_ERROR);
  assign o_err            = r_err;
  assign o_err_code       = r_errCode;
  assign o_retired        = r_retired;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer: walks R-type, LW, SW, ADDI, an
// illegal opcode, fetch timeout and counter wrap through the sequencer, checking
// every strobe, the error state and the retired count each cycle.
module tb_multicycle_sequencer;

  localparam int CNT_W = 4;

  // Expected strobe patterns: {req, addr_sel, we, ir_write, pc_write, reg_write_en, busy, err}
  localparam logic [7:0] E_IDLE      = 8'b0000_0000;
  localparam logic [7:0] E_FETCH     = 8'b1000_0010;
  localparam logic [7:0] E_FETCH_ACK = 8'b1001_0010;
  localparam logic [7:0] E_BUSY      = 8'b0000_0010;
  localparam logic [7:0] E_WB_RW     = 8'b0000_1110;
  localparam logic [7:0] E_WB_NORW   = 8'b0000_1010;
  localparam logic [7:0] E_MEM_RD    = 8'b1100_0010;
  localparam logic [7:0] E_MEM_WR    = 8'b1110_0010;
  localparam logic [7:0] E_MEM_WRACK = 8'b1110_1010;
  localparam logic [7:0] E_ERROR     = 8'b0000_0001;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             stop;
  logic [6:0]       opcode;
  logic             ctlRegWrite;
  logic             ctlMemWrite;
  logic             irWrite;
  logic             pcWrite;
  logic             regWriteEn;
  logic             busy;
  logic             err;
  logic [1:0]       errCode;
  logic [CNT_W-1:0] retired;

  int               vectors;
  int               miscompares;
  logic [CNT_W-1:0] expRet;

  multicycle_sequencer_if bus ();

  multicycle_sequencer #(
    .MEM_TIMEOUT (15),
    .CNT_W       (CNT_W)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_start         (start),
    .i_stop          (stop),
    .i_opcode        (opcode),
    .i_ctl_reg_write (ctlRegWrite),
    .i_ctl_mem_write (ctlMemWrite),
    .mem             (bus),
    .o_ir_write      (irWrite),
    .o_pc_write      (pcWrite),
    .o_reg_write_en  (regWriteEn),
    .o_busy          (busy),
    .o_err           (err),
    .o_err_code      (errCode),
    .o_retired       (retired)
  );

  // Free-running clock; rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle's inputs at the falling edge and let outputs settle.
  task automatic applyStimulus(input logic st, input logic sp, input logic [6:0] op,
                               input logic rw, input logic mw, input logic ack);
    @(negedge clk);
    start       = st;
    stop        = sp;
    opcode      = op;
    ctlRegWrite = rw;
    ctlMemWrite = mw;
    bus.mem_ack = ack;
    #1;
  endtask

  // Compare every output against the hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [7:0] expStrobes,
                             input logic [1:0] expCode);
    logic [13:0] obs;
    logic [13:0] exp;
    obs = {bus.mem_req, bus.mem_addr_sel, bus.mem_we, irWrite, pcWrite, regWriteEn,
           busy, err, errCode, retired};
    exp = {expStrobes, expCode, expRet};
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%b expected=%b (req,sel,we,irw,pcw,rwe,busy,err,code,retired)",
             tag, obs, exp);
    end
  endtask

  task automatic step(input logic st, input logic sp, input logic [6:0] op,
                      input logic rw, input logic mw, input logic ack,
                      input string tag, input logic [7:0] expStrobes,
                      input logic [1:0] expCode);
    applyStimulus(st, sp, op, rw, mw, ack);
    checkOutput(tag, expStrobes, expCode);
  endtask

  // Pulse reset low for one cycle; every output must be zero while it is held.
  task automatic doReset(input string tag);
    @(negedge clk);
    rst_n       = 1'b0;
    start       = 1'b0;
    stop        = 1'b0;
    bus.mem_ack = 1'b0;
    expRet      = '0;
    #1;
    checkOutput(tag, E_IDLE, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    expRet      = '0;
    rst_n       = 1'b0;
    start       = 1'b0;
    stop        = 1'b0;
    opcode      = 7'd0;
    ctlRegWrite = 1'b0;
    ctlMemWrite = 1'b0;
    bus.mem_ack = 1'b0;

    doReset("reset_state");

    // R-type with zero-wait memory; ack in DECODE must be ignored.
    step(1, 0, OP_R, 1, 0, 0, "r_idle",   E_IDLE,      2'b00);
    step(0, 0, OP_R, 1, 0, 1, "r_fetch",  E_FETCH_ACK, 2'b00);
    step(0, 0, OP_R, 1, 0, 1, "r_decode", E_BUSY,      2'b00);
    step(0, 0, OP_R, 1, 0, 0, "r_exec",   E_BUSY,      2'b00);
    step(0, 0, OP_R, 1, 0, 0, "r_wb",     E_WB_RW,     2'b00);
    expRet = 4'd1;

    // LW straight after, with three wait cycles in MEM.
    step(0, 0, OP_LW, 1, 0, 1, "lw_fetch",  E_FETCH_ACK, 2'b00);
    step(0, 0, OP_LW, 1, 0, 0, "lw_decode", E_BUSY,      2'b00);
    step(0, 0, OP_LW, 1, 0, 0, "lw_exec",   E_BUSY,      2'b00);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, OP_LW, 1, 0, 0, "lw_mem_wait", E_MEM_RD, 2'b00);
    end
    step(0, 0, OP_LW, 1, 0, 1, "lw_mem_ack", E_MEM_RD, 2'b00);
    step(0, 1, OP_LW, 1, 0, 0, "lw_wb",      E_WB_RW,  2'b00);
    expRet = 4'd2;
    step(0, 0, OP_LW, 1, 0, 0, "lw_idle",    E_IDLE,   2'b00);

    // SW: write qualifier only in MEM, no register write, pc_write on ack.
    step(1, 0, OP_SW, 1, 1, 0, "sw_idle",    E_IDLE,      2'b00);
    step(0, 0, OP_SW, 1, 1, 1, "sw_fetch",   E_FETCH_ACK, 2'b00);
    step(0, 0, OP_SW, 1, 1, 0, "sw_decode",  E_BUSY,      2'b00);
    step(0, 0, OP_SW, 1, 1, 0, "sw_exec",    E_BUSY,      2'b00);
    step(0, 0, OP_SW, 1, 1, 0, "sw_mem_wait", E_MEM_WR,   2'b00);
    step(0, 1, OP_SW, 1, 1, 1, "sw_mem_ack", E_MEM_WRACK, 2'b00);
    expRet = 4'd3;
    step(0, 0, OP_SW, 1, 1, 0, "sw_done",    E_IDLE,      2'b00);

    // start and stop together: exactly one ADDI, then back to IDLE.
    step(1, 1, OP_I, 0, 0, 0, "ss_idle",   E_IDLE,      2'b00);
    step(1, 1, OP_I, 0, 0, 1, "ss_fetch",  E_FETCH_ACK, 2'b00);
    step(1, 1, OP_I, 0, 0, 0, "ss_decode", E_BUSY,      2'b00);
    step(1, 1, OP_I, 0, 0, 0, "ss_exec",   E_BUSY,      2'b00);
    step(1, 1, OP_I, 0, 0, 0, "ss_wb",     E_WB_NORW,   2'b00);
    expRet = 4'd4;
    step(0, 0, OP_I, 0, 0, 0, "ss_back_idle", E_IDLE,   2'b00);

    // Fetch acked in the 15th request cycle: ack wins over the timeout.
    step(1, 0, OP_R, 1, 0, 0, "late_idle", E_IDLE, 2'b00);
    for (int i = 1; i < 15; i++) begin
      step(0, 0, OP_R, 1, 0, 0, "late_fetch_wait", E_FETCH, 2'b00);
    end
    step(0, 0, OP_R, 1, 0, 1, "late_fetch_ack", E_FETCH_ACK, 2'b00);
    step(0, 0, OP_R, 1, 0, 0, "late_decode",    E_BUSY,      2'b00);
    step(0, 0, OP_R, 1, 0, 0, "late_exec",      E_BUSY,      2'b00);
    step(0, 1, OP_R, 1, 0, 0, "late_wb",        E_WB_RW,     2'b00);
    expRet = 4'd5;
    step(0, 0, OP_R, 1, 0, 0, "late_done",      E_IDLE,      2'b00);

    // Fetch never acked: ERROR with code 10 after 15 request cycles.
    step(1, 0, OP_R, 1, 0, 0, "to_idle", E_IDLE, 2'b00);
    for (int i = 0; i < 15; i++) begin
      step(0, 0, OP_R, 1, 0, 0, "to_fetch_wait", E_FETCH, 2'b00);
    end
    step(1, 1, OP_R, 1, 0, 1, "to_error",      E_ERROR, 2'b10);
    step(1, 0, OP_R, 1, 0, 1, "to_error_held", E_ERROR, 2'b10);
    doReset("to_reset");

    // Illegal opcode: ERROR after DECODE, start ignored until reset.
    step(1, 0, OP_BR, 1, 1, 0, "ill_idle",   E_IDLE,      2'b00);
    step(0, 0, OP_BR, 1, 1, 1, "ill_fetch",  E_FETCH_ACK, 2'b00);
    step(1, 0, OP_BR, 1, 1, 0, "ill_decode", E_BUSY,      2'b00);
    step(1, 0, OP_BR, 1, 1, 0, "ill_error",  E_ERROR,     2'b01);
    step(1, 0, OP_BR, 1, 1, 1, "ill_held1",  E_ERROR,     2'b01);
    step(1, 1, OP_BR, 1, 1, 0, "ill_held2",  E_ERROR,     2'b01);
    doReset("ill_reset");
    step(0, 0, OP_I, 1, 0, 0, "ill_clear", E_IDLE, 2'b00);

    // 17 zero-wait ADDIs on a 4-bit counter: wraps to 1.
    step(1, 0, OP_I, 1, 0, 0, "wrap_idle", E_IDLE, 2'b00);
    for (int i = 0; i < 17; i++) begin
      step(0, 0, OP_I, 1, 0, 1, "wrap_fetch",  E_FETCH_ACK, 2'b00);
      step(0, 0, OP_I, 1, 0, 0, "wrap_decode", E_BUSY,      2'b00);
      step(0, 0, OP_I, 1, 0, 0, "wrap_exec",   E_BUSY,      2'b00);
      step(0, (i == 16), OP_I, 1, 0, 0, "wrap_wb", E_WB_RW, 2'b00);
      expRet = expRet + 4'd1;
    end
    step(0, 0, OP_I, 1, 0, 0, "wrap_done", E_IDLE, 2'b00);

    // Reset in the middle of a pending load: request drops at once.
    step(1, 0, OP_LW, 1, 0, 0, "rst_idle",   E_IDLE,      2'b00);
    step(0, 0, OP_LW, 1, 0, 1, "rst_fetch",  E_FETCH_ACK, 2'b00);
    step(0, 0, OP_LW, 1, 0, 0, "rst_decode", E_BUSY,      2'b00);
    step(0, 0, OP_LW, 1, 0, 0, "rst_exec",   E_BUSY,      2'b00);
    step(0, 0, OP_LW, 1, 0, 0, "rst_mem",    E_MEM_RD,    2'b00);
    doReset("rst_mid_mem");
    step(0, 0, OP_LW, 1, 0, 1, "rst_after", E_IDLE, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
